// File: rtl/bidir_bus_pkg.sv
// ============================================================================
//  Module      : bidir_bus_pkg
//  Description : Shared types and constants for the half-duplex pad bus
//                controller (FSM states, turnaround destination, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bidir_bus_pkg;

    localparam int TURN_CYCLES_MAX = 15;
    localparam int TURN_CNT_W      = $clog2(TURN_CYCLES_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        LISTEN = 2'd3
    } bidir_state_t;

    typedef enum logic [0:0] {
        DIR_IDLE   = 1'b0,
        DIR_LISTEN = 1'b1
    } bidir_dir_t;

endpackage

`default_nettype wire

// File: rtl/bidir_turn_timer.sv
// ============================================================================
//  Module      : bidir_turn_timer
//  Description : Loadable down-counter; done is high while the count is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidir_turn_timer
    import bidir_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [TURN_CNT_W-1:0] load_val_i,
    input  logic                  en_i,
    output logic                  done_o
);

    logic [TURN_CNT_W-1:0] count_q;
    logic [TURN_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/bidir_bus_ctrl.sv
// ============================================================================
//  Module      : bidir_bus_ctrl
//  Description : Half-duplex controller for a shared bidirectional pad bus with
//                a turnaround FSM. Optional even parity via BIDIR_BUS_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidir_bus_ctrl
    import bidir_bus_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             remote_req,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
`ifdef BIDIR_BUS_PARITY_EN
    output logic [WIDTH:0]   bus_out,
    output logic             bus_oe,
    input  logic [WIDTH:0]   bus_in,
    output logic             rx_perr,
`else
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic [WIDTH-1:0] bus_in,
`endif
    output logic             busy
);

`ifdef BIDIR_BUS_PARITY_EN
    localparam int BUS_W = WIDTH + 1;
`else
    localparam int BUS_W = WIDTH;
`endif

    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN_CYCLES - 1);

    bidir_state_t     state_q, state_d;
    bidir_dir_t       dir_q, dir_d;
    logic [BUS_W-1:0] bus_out_q, bus_out_d;
    logic             bus_oe_q, bus_oe_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_perr_q, rx_perr_d;
    logic [BUS_W-1:0] tx_word;
    logic             cap_perr;
    logic             tx_hs;
    logic             turn_load;
    logic             turn_done;

`ifdef BIDIR_BUS_PARITY_EN
    assign tx_word  = {^tx_data, tx_data};
    assign cap_perr = bus_in[WIDTH] ^ (^bus_in[WIDTH-1:0]);
`else
    assign tx_word  = tx_data;
    assign cap_perr = 1'b0;
`endif

    // Gated by rst so nothing is accepted in a cycle that reset will discard.
    assign tx_ready = !rst && !remote_req && ((state_q == IDLE) || (state_q == DRIVE));
    assign tx_hs    = tx_valid && tx_ready;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        bus_out_d  = bus_out_q;
        bus_oe_d   = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = 1'b0;
        turn_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (remote_req) begin
                    state_d = LISTEN;
                end else if (tx_hs) begin
                    bus_out_d = tx_word;
                    bus_oe_d  = 1'b1;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                if (tx_hs) begin
                    bus_out_d = tx_word;
                    bus_oe_d  = 1'b1;
                end else begin
                    state_d   = TURN;
                    turn_load = 1'b1;
                    dir_d     = remote_req ? DIR_LISTEN : DIR_IDLE;
                end
            end
            TURN: begin
                if (turn_done) begin
                    // A remote that gave up during turnaround leaves us idle.
                    state_d = ((dir_q == DIR_LISTEN) && remote_req) ? LISTEN : IDLE;
                end
            end
            LISTEN: begin
                if (remote_req) begin
                    rx_data_d  = bus_in[WIDTH-1:0];
                    rx_valid_d = 1'b1;
                    rx_perr_d  = cap_perr;
                end else begin
                    state_d   = TURN;
                    turn_load = 1'b1;
                    dir_d     = DIR_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= DIR_IDLE;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    bidir_turn_timer u_turn_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (turn_load),
        .load_val_i (TURN_LOAD),
        .en_i       (state_q == TURN),
        .done_o     (turn_done)
    );

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);

`ifdef BIDIR_BUS_PARITY_EN
    assign rx_perr = rx_perr_q;
`else
    logic unused_perr;
    assign unused_perr = rx_perr_q ^ rx_perr_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
// ============================================================================
//  Module      : tb_bidir_bus_ctrl
//  Description : Directed scoreboard bench for bidir_bus_ctrl (TURN_CYCLES=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bidir_bus_ctrl;

    localparam int WIDTH = 4;
`ifdef BIDIR_BUS_PARITY_EN
    localparam int BW = WIDTH + 1;
`else
    localparam int BW = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             remote_req;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic [BW-1:0]    bus_out;
    logic             bus_oe;
    logic [BW-1:0]    bus_in;
    logic             busy;
`ifdef BIDIR_BUS_PARITY_EN
    logic             rx_perr;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] tx_q[$];
    logic [8:0] rx_q[$];

    always #5 clk = ~clk;

    bidir_bus_ctrl #(.WIDTH(WIDTH), .TURN_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .remote_req (remote_req),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .bus_in     (bus_in),
`ifdef BIDIR_BUS_PARITY_EN
        .rx_perr    (rx_perr),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_tx(input logic [WIDTH-1:0] d);
        logic [8:0] r;
        r = 9'(d);
`ifdef BIDIR_BUS_PARITY_EN
        r[WIDTH] = ^d;
`endif
        return r;
    endfunction

    // Remote drives a word; bad_par flips the parity bit in the parity build.
    task automatic rx_word(input logic [WIDTH-1:0] d, input logic bad_par);
        logic [8:0] w;
        w = 9'(d);
`ifdef BIDIR_BUS_PARITY_EN
        w[WIDTH] = (^d) ^ bad_par;
`endif
        bus_in = w[BW-1:0];
        rx_q.push_back({bad_par, 4'(0), d});
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_q.push_back(exp_tx(d));
    endtask

    task automatic tick(input logic exp_oe, input logic exp_rxv);
        logic [8:0] e;
        @(posedge clk);
        #1;
        chk("bus_oe", 32'(bus_oe), 32'(exp_oe));
        chk("rx_valid", 32'(rx_valid), 32'(exp_rxv));
        if (bus_oe === 1'b1) begin
            chk("tx_sb_nonempty", 32'(tx_q.size() > 0), 32'd1);
            if (tx_q.size() > 0) begin
                e = tx_q.pop_front();
                chk("bus_out", 32'(bus_out), 32'(e[BW-1:0]));
            end
        end
        if (rx_valid === 1'b1) begin
            chk("rx_sb_nonempty", 32'(rx_q.size() > 0), 32'd1);
            if (rx_q.size() > 0) begin
                e = rx_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e[WIDTH-1:0]));
`ifdef BIDIR_BUS_PARITY_EN
                chk("rx_perr", 32'(rx_perr), 32'(e[8]));
`endif
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = '0;
        remote_req = 1'b0;
        bus_in     = '0;

        // Reset state
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_bus_out", 32'(bus_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;

        // Streaming A, B, C then a two-cycle turnaround back to IDLE
        send(4'hA);
        #1 chk("idle_tx_ready", 32'(tx_ready), 32'd1);
        tick(1'b1, 1'b0);
        send(4'hB);
        #1 chk("drive_tx_ready", 32'(tx_ready), 32'd1);
        tick(1'b1, 1'b0);
        send(4'hC);
        tick(1'b1, 1'b0);
        tx_valid = 1'b0;
        tick(1'b0, 1'b0);
        chk("turn_busy", 32'(busy), 32'd1);
        chk("turn_tx_ready", 32'(tx_ready), 32'd0);
        tick(1'b0, 1'b0);
        chk("turn2_busy", 32'(busy), 32'd1);
        tick(1'b0, 1'b0);
        chk("post_turn_busy", 32'(busy), 32'd0);
        chk("post_turn_tx_ready", 32'(tx_ready), 32'd1);

        // Remote capture of 1, 2, 4
        remote_req = 1'b1;
        bus_in     = '1;
        #1 chk("req_tx_ready", 32'(tx_ready), 32'd0);
        tick(1'b0, 1'b0);
        chk("listen_busy", 32'(busy), 32'd1);
        rx_word(4'h1, 1'b0);
        tick(1'b0, 1'b1);
        rx_word(4'h2, 1'b0);
        tick(1'b0, 1'b1);
        rx_word(4'h4, 1'b0);
        tick(1'b0, 1'b1);
        remote_req = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rx_done_busy", 32'(busy), 32'd0);

        // Simultaneous tx_valid and remote_req: remote wins
        tx_valid   = 1'b1;
        tx_data    = 4'h6;
        remote_req = 1'b1;
        #1 chk("simul_tx_ready", 32'(tx_ready), 32'd0);
        tick(1'b0, 1'b0);
        rx_word(4'h3, 1'b0);
        tick(1'b0, 1'b1);
        chk("simul_listen_tx_ready", 32'(tx_ready), 32'd0);
        tx_valid   = 1'b0;
        remote_req = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("simul_done_busy", 32'(busy), 32'd0);

        // Preemption while 0x9 is driven; new tx_data must be ignored
        send(4'h9);
        tick(1'b1, 1'b0);
        tx_data    = 4'hD;
        remote_req = 1'b1;
        #1 chk("preempt_tx_ready", 32'(tx_ready), 32'd0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tx_valid = 1'b0;
        rx_word(4'h8, 1'b0);
        tick(1'b0, 1'b1);
        remote_req = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("preempt_done_busy", 32'(busy), 32'd0);

        // Remote gives up during turnaround: return to IDLE, no capture
        send(4'h1);
        tick(1'b1, 1'b0);
        tx_valid   = 1'b0;
        remote_req = 1'b1;
        tick(1'b0, 1'b0);
        remote_req = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("abandon_busy", 32'(busy), 32'd0);
        tick(1'b0, 1'b0);

        // Reset mid-DRIVE
        send(4'h3);
        tick(1'b1, 1'b0);
        send(4'h5);
        tick(1'b1, 1'b0);
        tx_valid = 1'b0;
        rst      = 1'b1;
        tick(1'b0, 1'b0);
        chk("mid_rst_bus_out", 32'(bus_out), 32'd0);
        chk("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

`ifdef BIDIR_BUS_PARITY_EN
        // Parity generation on tx and mismatch detection on capture
        send(4'h7);
        tick(1'b1, 1'b0);
        chk("par_tx_word", 32'(bus_out), 32'h17);
        tx_valid = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        remote_req = 1'b1;
        tick(1'b0, 1'b0);
        rx_word(4'h7, 1'b1);
        chk("par_rx_bus_in", 32'(bus_in), 32'h07);
        tick(1'b0, 1'b1);
        chk("par_rx_perr", 32'(rx_perr), 32'd1);
        remote_req = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
`endif

        chk("tx_sb_drained", 32'(tx_q.size()), 32'd0);
        chk("rx_sb_drained", 32'(rx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bidir_bus_ctrl.md
Name: bidir_bus_ctrl

Overview:
- Half-duplex controller for a shared WIDTH-bit bidirectional pad bus. Pad is modelled as a separate out/oe/in triplet so STA graph bidirect vertices are explicit.
- Serialises a local valid/ready stream onto the bus and captures remote-driven words back into a valid stream.
- A turnaround FSM guarantees that both ends never drive the bus at the same time.
- Sits between core logic and the bidirect pad ring. It is the driving counterpart to register-capture consumer logic.

Parameters:
- WIDTH, 4, data bits on the bus.
- TURN_CYCLES, 1, dead cycles with bus_oe=0 on every direction change. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  local word available.
- tx_ready  out  1  controller accepts tx_data this cycle.
- tx_data  in  WIDTH  local word to drive.
- remote_req  in  1  remote end requests or holds bus ownership.
- rx_valid  out  1  rx_data holds a captured word; one-cycle pulse per word, no backpressure.
- rx_data  out  WIDTH  captured bus word.
- bus_out  out  WIDTH  pad output data.
- bus_oe  out  1  pad output enable; 1 means local end drives.
- bus_in  in  WIDTH  pad input data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (takes effect at the clk edge where rst=1, in any state): state=IDLE, bus_oe=0, bus_out=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, turn counter=0. A transfer in flight is abandoned; no partial word is flagged.
- States: IDLE, DRIVE, TURN, LISTEN. A registered next_dir bit selects the destination after TURN (IDLE or LISTEN).
- tx_ready is combinational: 1 in IDLE when remote_req=0, and 1 in DRIVE when remote_req=0. Otherwise 0.
- IDLE:
  - remote_req=1 has priority over tx_valid: next state LISTEN, with no turnaround (bus already released).
  - Else tx_valid=1 (handshake): bus_out<=tx_data, bus_oe<=1, next state DRIVE.
- DRIVE:
  - Each cycle bus_out holds the last accepted word and bus_oe=1.
  - tx_valid&tx_ready loads the next word: back-to-back streaming, one word per clock.
  - No handshake and remote_req=0: bus_oe<=0, next TURN, next_dir=IDLE.
  - remote_req=1: tx_ready=0, bus_oe<=0, next TURN, next_dir=LISTEN. The word already on the bus completes its cycle.
- TURN:
  - bus_oe=0 for exactly TURN_CYCLES cycles, counted down from TURN_CYCLES-1.
  - Then go to next_dir. If next_dir=LISTEN but remote_req has dropped, go to IDLE.
- LISTEN:
  - bus_oe=0. While remote_req=1, each cycle rx_data<=bus_in and rx_valid<=1. Latency is 1 clk from bus_in to rx_data.
  - When remote_req=0: rx_valid<=0, next TURN, next_dir=IDLE.
- Invariant: bus_oe=1 only in DRIVE. bus_oe is never 1 in the cycle immediately after LISTEN.
- rx_valid and tx_ready are never both 1.
- tx_data is ignored whenever tx_ready=0.

Optional Feature:
- Macro BIDIR_BUS_PARITY_EN.
- Defined:
  - bus_out and bus_in widen to WIDTH+1. The MSB carries even parity (XOR of the data bits), generated on load.
  - In LISTEN, a parity mismatch on a captured word asserts added output rx_perr (1 bit) in the same cycle as its rx_valid. Data is still delivered.
  - rx_perr resets to 0.
- Undefined: buses are WIDTH bits and there is no rx_perr port.

Decomposition:
- Package bidir_bus_pkg holds:
  - state enum (IDLE, DRIVE, TURN, LISTEN) as typedef bidir_state_t;
  - dir enum for next_dir;
  - TURN_CNT_W constant derived with clog2.
- One sub-module, bidir_turn_timer: loadable down-counter with a done flag, used by TURN.
- FSM and datapath stay in bidir_bus_ctrl.

Test Plan:
- Reset mid-DRIVE:
  - Stimulus: streaming tx of 0x3 then 0x5; assert rst at the cycle 0x5 is on the bus.
  - Response: next cycle bus_oe=0, bus_out=0, tx_ready=0, busy=0.
- Streaming tx, TURN_CYCLES=2:
  - Stimulus: tx_valid held for words 0xA, 0xB, 0xC.
  - Response: bus_out=A,B,C on consecutive cycles with bus_oe=1; then 2 cycles bus_oe=0; then IDLE with tx_ready=1.
- Remote capture:
  - Stimulus: in IDLE, remote_req=1 for 3 cycles with bus_in=0x1,0x2,0x4.
  - Response: rx_valid pulses 3 cycles with rx_data 0x1,0x2,0x4, each 1 clk late; bus_oe stays 0.
- Simultaneous request in IDLE:
  - Stimulus: tx_valid=1 and remote_req=1 together.
  - Response: tx_ready=0, state LISTEN, bus_oe never 1.
- Preemption during DRIVE:
  - Stimulus: remote_req=1 raised while word 0x9 is driven.
  - Response: 0x9 held for one cycle; bus_oe=0 for TURN_CYCLES; then LISTEN captures bus_in.
  - Check: bus_oe and remote_req never overlap after the turnaround.
- BIDIR_BUS_PARITY_EN:
  - Stimulus: tx 0x7; then remote drives 5'b0_0111 in LISTEN.
  - Response: tx drives 5'b1_0111; the capture gives rx_valid=1 and rx_perr=1.
